// File: rtl/sram_read_arbiter.sv
// Two-port read arbiter for the shared input SRAM: round-robin with bounded burst lock,
// registered address issue and a tag pipeline that routes returned data to its requester.
module sram_read_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 16,
   parameter int RD_LAT   = 2,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              r0_req,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic              r0_lock,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   input  logic              r1_req,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic              r1_lock,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] sram_raddr,
   output logic              sram_ren,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t            r_state, w_nstate;
   logic [CNT_W-1:0]  r_lock_cnt, w_ncnt;
   logic              r_last;
   logic [ADDR_W-1:0] r_raddr;
   logic              r_ren;
   logic [RD_LAT-1:0] r_tag_vld;
   logic [RD_LAT-1:0] r_tag_id;

   logic w_any, w_win, w_win_lock, w_arb, w_gnt0, w_gnt1, w_gnt, w_owner;
   logic w_oreq, w_olock, w_xreq;

   // IDLE-rule winner: a lone requester wins, a conflict goes to the one not served last
   assign w_any      = r0_req | r1_req;
   assign w_win      = (r0_req & r1_req) ? ~r_last : r1_req;
   assign w_win_lock = w_win ? r1_lock : r0_lock;

   assign w_owner = (r_state == OWN1);
   assign w_oreq  = w_owner ? r1_req  : r0_req;
   assign w_olock = w_owner ? r1_lock : r0_lock;
   assign w_xreq  = w_owner ? r0_req  : r1_req;

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_lock_cnt;
      w_gnt0   = 1'b0;
      w_gnt1   = 1'b0;
      w_arb    = 1'b0;
      if (r_state == IDLE || !w_olock) begin
         w_arb = 1'b1;
      end else if (r_lock_cnt == CNT_W'(MAX_LOCK) && w_xreq) begin
         // forced handover beats the owner's own request
         w_gnt0   = w_owner;
         w_gnt1   = ~w_owner;
         w_nstate = IDLE;
         w_ncnt   = '0;
      end else if (w_oreq) begin
         w_gnt0 = ~w_owner;
         w_gnt1 = w_owner;
         if (r_lock_cnt != CNT_W'(MAX_LOCK))
            w_ncnt = r_lock_cnt + CNT_W'(1);
      end
      if (w_arb) begin
         w_nstate = IDLE;
         w_ncnt   = '0;
         if (w_any) begin
            w_gnt0 = ~w_win;
            w_gnt1 = w_win;
            if (w_win_lock) begin
               w_nstate = w_win ? OWN1 : OWN0;
               w_ncnt   = CNT_W'(1);
            end
         end
      end
   end

   assign w_gnt = w_gnt0 | w_gnt1;

   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         r_state    <= IDLE;
         r_lock_cnt <= '0;
         r_last     <= 1'b1;
         r_raddr    <= '0;
         r_ren      <= 1'b0;
         r_tag_vld  <= '0;
         r_tag_id   <= '0;
      end else begin
         r_state    <= w_nstate;
         r_lock_cnt <= w_ncnt;
         r_ren      <= w_gnt;
         if (w_gnt) begin
            r_last  <= w_gnt1;
            r_raddr <= w_gnt1 ? r1_addr : r0_addr;
         end
         r_tag_vld[0] <= w_gnt;
         r_tag_id[0]  <= w_gnt1;
         for (int i = 1; i < RD_LAT; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_id[i]  <= r_tag_id[i-1];
         end
      end
   end

   assign r0_gnt     = w_gnt0;
   assign r1_gnt     = w_gnt1;
   assign sram_raddr = r_raddr;
   assign sram_ren   = r_ren;
   assign rdata      = sram_rdata;
   assign busy       = |r_tag_vld;
   assign r0_rvalid  = r_tag_vld[RD_LAT-1] & ~r_tag_id[RD_LAT-1];
   assign r1_rvalid  = r_tag_vld[RD_LAT-1] &  r_tag_id[RD_LAT-1];

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter: a behavioural SRAM plus a scoreboard of expected
// read returns, with grants, issue and returns checked every cycle.
module tb_sram_read_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              reset_b;
   logic              r0_req, r0_lock, r1_req, r1_lock;
   logic [ADDR_W-1:0] r0_addr, r1_addr;
   logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [DATA_W-1:0] rdata, sram_rdata;
   logic [ADDR_W-1:0] sram_raddr;
   logic              sram_ren, busy;

   typedef struct {
      logic              id;
      logic [DATA_W-1:0] data;
      int                due;
   } rd_t;

   rd_t               sb[$];
   int                tests = 0;
   int                fails = 0;
   int                cyc   = 0;
   logic              prev_g = 1'b0;
   logic [ADDR_W-1:0] prev_a = '0;

   sram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_LOCK(8)) dut (
      .clk(clk), .reset_b(reset_b),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_lock(r0_lock), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
      .rdata(rdata), .sram_raddr(sram_raddr), .sram_ren(sram_ren), .sram_rdata(sram_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mem(input logic [ADDR_W-1:0] a);
      return {a[3:0], a} ^ 16'h5A3C;
   endfunction

   // one-cycle-latency SRAM behind the registered address gives RD_LAT = 2 from grant
   always @(posedge clk) begin
      if (sram_ren) sram_rdata <= mem(sram_raddr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ren"},   32'(sram_ren), 0);
      chk({tag, "_raddr"}, 32'(sram_raddr), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_rv0"},   32'(r0_rvalid), 0);
      chk({tag, "_rv1"},   32'(r1_rvalid), 0);
   endtask

   task automatic do_reset();
      reset_b = 1'b1;
      #1;
      chk_reset_state("rst");
      sb.delete();
      prev_g = 1'b0;
      @(posedge clk);
      #1;
      reset_b = 1'b0;
      cyc++;
   endtask

   task automatic step(input logic q0, input logic [ADDR_W-1:0] a0, input logic l0,
                       input logic q1, input logic [ADDR_W-1:0] a1, input logic l1,
                       input logic eg0, input logic eg1);
      r0_req = q0; r0_addr = a0; r0_lock = l0;
      r1_req = q1; r1_addr = a1; r1_lock = l1;
      @(negedge clk);
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      chk("gnt0", 32'(r0_gnt), 32'(eg0));
      chk("gnt1", 32'(r1_gnt), 32'(eg1));
      chk("ren",  32'(sram_ren), 32'(prev_g));
      if (prev_g) chk("raddr", 32'(sram_raddr), 32'(prev_a));
      if (sb.size() != 0 && sb[0].due == cyc) begin
         chk("rv0",   32'(r0_rvalid), 32'(sb[0].id == 1'b0));
         chk("rv1",   32'(r1_rvalid), 32'(sb[0].id == 1'b1));
         chk("rdata", 32'(rdata), 32'(sb[0].data));
         void'(sb.pop_front());
      end else begin
         chk("rv0_idle", 32'(r0_rvalid), 0);
         chk("rv1_idle", 32'(r1_rvalid), 0);
      end
      if (eg0 | eg1) sb.push_back('{id: eg1, data: mem(eg1 ? a1 : a0), due: cyc + RD_LAT});
      prev_g = eg0 | eg1;
      prev_a = eg1 ? a1 : a0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset_b = 1'b1;
      r0_req = 0; r0_addr = '0; r0_lock = 0;
      r1_req = 0; r1_addr = '0; r1_lock = 0;
      @(posedge clk);
      do_reset();

      // single requester, back-to-back addresses 0,1,2
      for (int i = 0; i < 3; i++) step(1, 12'(i), 0, 0, 0, 0, 1, 0);
      idle(3);

      // both held from reset, no lock: strict alternation starting with r0
      do_reset();
      step(1, 12'h010, 0, 1, 12'h020, 0, 1, 0);
      step(1, 12'h011, 0, 1, 12'h020, 0, 0, 1);
      step(1, 12'h011, 0, 1, 12'h021, 0, 1, 0);
      step(1, 12'h012, 0, 1, 12'h021, 0, 0, 1);
      idle(3);

      // r1 burst lock: 8 grants, forced handover to r0, then plain round-robin
      step(0, 12'h0A0, 0, 1, 12'h100, 1, 0, 1);
      for (int i = 1; i < 8; i++) step(1, 12'h0A0, 0, 1, 12'(12'h100 + i), 1, 0, 1);
      step(1, 12'h0A0, 0, 1, 12'h108, 1, 1, 0);
      step(1, 12'h0A1, 0, 1, 12'h108, 0, 0, 1);
      step(1, 12'h0A1, 0, 1, 12'h109, 0, 1, 0);
      idle(3);

      // r0 owns the lock and pauses: r1 stays blocked, no issue
      step(1, 12'h300, 1, 0, 12'h400, 0, 1, 0);
      step(0, 12'h301, 1, 1, 12'h400, 0, 0, 0);
      step(0, 12'h301, 1, 1, 12'h400, 0, 0, 0);
      step(1, 12'h301, 1, 1, 12'h400, 0, 1, 0);
      // lock dropped while both request, last winner r0: r1 wins
      step(1, 12'h302, 0, 1, 12'h400, 0, 0, 1);
      idle(3);

      // asynchronous reset with two reads in flight
      step(1, 12'h555, 0, 0, 12'h666, 0, 1, 0);
      step(0, 12'h555, 0, 1, 12'h666, 0, 0, 1);
      chk("busy_inflight", 32'(busy), 1);
      do_reset();
      idle(4);
      // last winner back to r1 after reset: r0 takes the first conflict
      step(1, 12'h777, 0, 1, 12'h888, 0, 1, 0);
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sram_read_arbiter.md
Name: sram_read_arbiter

Overview:
- Shares the single input-SRAM read port between two requesters: requester 0 is the main controller's row/dimension fetch path, requester 1 is the weight/auxiliary fetch path.
- Arbitrates round-robin, with an optional bounded burst lock that gives one requester back-to-back grants.
- Registers the winning address onto the SRAM and tracks fixed-latency reads through a tag pipeline, so returned data is flagged to the correct requester.

Parameters:
- ADDR_W, 12, SRAM read address width.
- DATA_W, 16, SRAM read data width.
- RD_LAT, 2, cycles from the grant cycle to the cycle in which sram_rdata holds the requested word (minimum 1).
- MAX_LOCK, 8, maximum consecutive locked grants before a contending requester is forced in.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_b  in  1  reset; asynchronous, active-high (1 = reset).
- r0_req  in  1  requester 0 read request.
- r0_addr  in  ADDR_W  requester 0 read address.
- r0_lock  in  1  requester 0 asks to keep ownership after its grant.
- r0_gnt  out  1  requester 0 granted this cycle (combinational).
- r0_rvalid  out  1  sram_rdata belongs to a requester 0 read this cycle.
- r1_req, r1_addr, r1_lock, r1_gnt, r1_rvalid: same widths and meaning for requester 1.
- rdata  out  DATA_W  sram_rdata passed through to both requesters.
- sram_raddr  out  ADDR_W  registered SRAM read address.
- sram_ren  out  1  registered; high for one cycle per issued read.
- sram_rdata  in  DATA_W  SRAM read data.
- busy  out  1  at least one read in flight in the tag pipeline.

Behaviour:
- Reset values:
  - sram_raddr = 0, sram_ren = 0, busy = 0.
  - All rvalid = 0.
  - Tag pipeline cleared.
  - FSM = IDLE, last_winner = 1 (so requester 0 wins the first conflict), lock_cnt = 0.
- Grant is combinational and given only to a requester whose req is high. At most one gnt per cycle.
- Issue: on the edge ending a grant cycle n:
  - sram_raddr <= winner's address.
  - sram_ren <= 1.
  - tag pipe stage 0 <= {valid = 1, id = winner}.
  - With no grant, sram_ren <= 0 and sram_raddr holds its value.
- Return: rX_rvalid is high in cycle n+RD_LAT, driven from the last tag stage. rdata = sram_rdata. One grant per cycle supports full throughput, one read per cycle.
- busy = OR of all tag-stage valid bits.
- FSM:
  - IDLE:
    - Only one req high: that requester wins.
    - Both high: the requester other than last_winner wins.
    - If the winner's lock is high: go to OWNx, lock_cnt = 1.
  - OWNx:
    - The owner wins whenever rx_req is high. The other requester is blocked even while the owner is idle for a cycle.
    - Each owner grant increments lock_cnt.
    - Exit to IDLE when the owner's lock is low (that cycle is arbitrated as in IDLE).
    - Also exit when lock_cnt == MAX_LOCK and the other requester is requesting: in that cycle the other requester is granted, and lock_cnt is cleared.
  - last_winner updates on every grant.
- Simultaneous events:
  - Owner drops lock in the same cycle as a request: arbitration for that cycle uses IDLE rules.
  - The forced handover at MAX_LOCK takes priority over the owner's request.
- Addresses are passed through unmodified. There is no wrap or range check; the requester owns its address range.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced afterward. Requesters must reissue.
- Requests are not queued. A requester holds req and addr stable until it sees gnt.

Test Plan:
- r0_req only, addresses 0,1,2 on consecutive cycles -> r0_gnt high 3 cycles; sram_raddr = 0,1,2 one cycle later; r0_rvalid high in cycles 2,3,4 relative to the first grant.
- r0_req and r1_req both held, no lock, from reset -> grants alternate r0,r1,r0,r1; each rvalid is tagged to the matching requester RD_LAT cycles after its grant.
- r1 locks with MAX_LOCK=8 and r0 requesting -> 8 consecutive r1 grants, then r0 is granted once, then the lock is no longer held by r1.
- r0 owns the lock but deasserts req for 2 cycles while r1 requests -> no grants and sram_ren = 0 for those cycles; r0 resumes and wins.
- Assert reset_b for 1 cycle with 2 reads in flight -> busy = 0 and no rvalid pulses follow; outputs return to reset values immediately (asynchronous).
- Lock dropped in the same cycle both requesters request, with last_winner = 0 -> r1 is granted that cycle.
